// File: rtl/buff_inject.sv
// rtl/buff_inject.sv - MinBD side-buffer reinjection, PE injection and starvation redirect stage
module buff_inject #(
  parameter int DEPTH      = 4,
  parameter int STARVE_LIM = 8,
  parameter int CW         = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [10:0]   ead,
  input  logic [10:0]   wad,
  input  logic [10:0]   nad,
  input  logic [10:0]   sad,
  input  logic [10:0]   sbuff,
  input  logic [10:0]   inj_flit,
  input  logic          inj_valid,
  output logic          inj_ready,
  output logic [10:0]   e_out,
  output logic [10:0]   w_out,
  output logic [10:0]   n_out,
  output logic [10:0]   s_out,
  output logic          buf_full,
  output logic [CW-1:0] buf_count,
  output logic          redirect,
  output logic          ovf_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(STARVE_LIM + 1);

  logic [10:0]       mem_q [DEPTH];
  logic [AW-1:0]     rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic [3:0][10:0]  slot, out_q, out_d;
  logic              full_q, full_d, red_q, red_d, ovf_q, ovf_d;

  logic [1:0]  pop_idx, inj_idx, red_idx;
  logic        any_free, inj_avail, red_found;
  logic        has_buf, is_full, pop, do_red, push_ok, wr_en;
  logic [10:0] head, wr_data;

  always_comb begin
    slot      = {sad, nad, wad, ead};
    out_d     = '0;
    pop_idx   = '0;
    inj_idx   = '0;
    red_idx   = '0;
    any_free  = 1'b0;
    inj_avail = 1'b0;
    red_found = 1'b0;
    has_buf   = (cnt_q != '0);
    is_full   = (cnt_q == CW'(DEPTH));
    head      = mem_q[rd_q];

    // Descending scans so the lowest matching index wins.
    for (int i = 3; i >= 0; i--) begin
      if (slot[i][10]) begin
        out_d[i] = slot[i];
        if (!slot[i][9]) begin
          red_found = 1'b1;
          red_idx   = 2'(i);
        end
      end else begin
        any_free = 1'b1;
        pop_idx  = 2'(i);
      end
    end

    pop = has_buf && any_free;

    for (int i = 3; i >= 0; i--) begin
      if (!slot[i][10] && !(pop && (2'(i) == pop_idx))) begin
        inj_avail = 1'b1;
        inj_idx   = 2'(i);
      end
    end

    inj_ready = inj_avail && !rst;
    do_red    = (starve_q == SW'(STARVE_LIM)) && !pop && has_buf && !sbuff[10] && red_found;

    if (pop) out_d[pop_idx] = head;
    if (inj_valid && inj_ready) out_d[inj_idx] = inj_flit;
    if (do_red) out_d[red_idx] = head;

    // A full FIFO still accepts a push when the head leaves this cycle.
    push_ok = sbuff[10] && (!is_full || pop);
    wr_en   = push_ok || do_red;
    wr_data = do_red ? slot[red_idx] : sbuff;

    rd_d   = rd_q + AW'(pop || do_red);
    wr_d   = wr_q + AW'(wr_en);
    cnt_d  = cnt_q + CW'(push_ok) - CW'(pop);
    full_d = (cnt_d == CW'(DEPTH));
    red_d  = do_red;
    ovf_d  = ovf_q || (sbuff[10] && is_full && !pop);

    if (pop || !has_buf || do_red) starve_d = '0;
    else if (starve_q == SW'(STARVE_LIM)) starve_d = starve_q;
    else starve_d = starve_q + SW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q    <= '0;
      rd_q     <= '0;
      wr_q     <= '0;
      cnt_q    <= '0;
      starve_q <= '0;
      full_q   <= 1'b0;
      red_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      out_q    <= out_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
      full_q   <= full_d;
      red_q    <= red_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_en) mem_q[wr_q] <= wr_data;
  end

  assign e_out     = out_q[0];
  assign w_out     = out_q[1];
  assign n_out     = out_q[2];
  assign s_out     = out_q[3];
  assign buf_full  = full_q;
  assign buf_count = cnt_q;
  assign redirect  = red_q;
  assign ovf_err   = ovf_q;
endmodule

// File: tb/tb_buff_inject.sv
// tb/tb_buff_inject.sv - scoreboard bench for buff_inject against a queue-based reference model
module tb_buff_inject;
  localparam int DEPTH = 4;
  localparam int LIM   = 8;
  localparam int CW    = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [10:0]   ead, wad, nad, sad, sbuff, inj_flit;
  logic          inj_valid, inj_ready;
  logic [10:0]   e_out, w_out, n_out, s_out;
  logic          buf_full, redirect, ovf_err;
  logic [CW-1:0] buf_count;

  buff_inject #(.DEPTH(DEPTH), .STARVE_LIM(LIM), .CW(CW)) dut (
    .clk(clk), .rst(rst), .ead(ead), .wad(wad), .nad(nad), .sad(sad),
    .sbuff(sbuff), .inj_flit(inj_flit), .inj_valid(inj_valid), .inj_ready(inj_ready),
    .e_out(e_out), .w_out(w_out), .n_out(n_out), .s_out(s_out),
    .buf_full(buf_full), .buf_count(buf_count), .redirect(redirect), .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0][10:0] o;
    logic [CW-1:0]    cnt;
    logic             full;
    logic             red;
    logic             ovf;
  } exp_t;

  exp_t        exp_q[$];
  logic        rdy_q[$];
  int          checks = 0;
  int          fails  = 0;

  logic [10:0] m_fifo[$];
  int          m_starve = 0;
  logic        m_ovf = 1'b0;

  // Drive one cycle of inputs and push the model's expected response.
  task automatic step(input logic r, input logic [10:0] e, w, n, s, sb, inj, input logic iv);
    exp_t        x;
    logic [10:0] sl[4];
    int          fr[$];
    logic        rdy, pop, red;
    int          k, pre, nfree;
    rst = r; ead = e; wad = w; nad = n; sad = s; sbuff = sb; inj_flit = inj; inj_valid = iv;
    #1;
    x   = '0;
    rdy = 1'b0;
    if (r) begin
      m_fifo.delete();
      m_starve = 0;
      m_ovf    = 1'b0;
    end else begin
      sl = '{e, w, n, s};
      for (int i = 0; i < 4; i++) begin
        if (sl[i][10]) x.o[i] = sl[i];
        else fr.push_back(i);
      end
      nfree = fr.size();
      pre   = m_fifo.size();
      pop   = (pre > 0) && (nfree > 0);
      if (pop) begin
        x.o[fr[0]] = m_fifo.pop_front();
        void'(fr.pop_front());
      end
      rdy = (fr.size() > 0);
      if (iv && rdy) x.o[fr[0]] = inj;
      red = 1'b0;
      k   = -1;
      for (int i = 3; i >= 0; i--) if (sl[i][10] && !sl[i][9]) k = i;
      if (m_starve == LIM && !pop && pre > 0 && !sb[10] && k >= 0) begin
        x.o[k] = m_fifo.pop_front();
        m_fifo.push_back(sl[k]);
        red = 1'b1;
      end
      if (sb[10]) begin
        if (m_fifo.size() < DEPTH) m_fifo.push_back(sb);
        else m_ovf = 1'b1;
      end
      if (pop || pre == 0 || red) m_starve = 0;
      else if (m_starve < LIM) m_starve++;
      x.cnt  = CW'(m_fifo.size());
      x.full = (m_fifo.size() == DEPTH);
      x.red  = red;
      x.ovf  = m_ovf;
    end
    exp_q.push_back(x);
    rdy_q.push_back(rdy);
    @(negedge clk);
  endtask

  function automatic logic [10:0] rf(input int pv);
    logic [10:0] f;
    f      = 11'($urandom);
    f[10]  = ($urandom_range(99) < pv);
    return f;
  endfunction

  function automatic logic [10:0] busy(input logic golden);
    return {1'b1, golden, 9'($urandom)};
  endfunction

  // Registered outputs appear after the edge that follows each stimulus cycle.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        checks++;
        if ({s_out, n_out, w_out, e_out} !== x.o) begin
          fails++;
          $display("FAIL slots got e=%h w=%h n=%h s=%h want e=%h w=%h n=%h s=%h",
                   e_out, w_out, n_out, s_out, x.o[0], x.o[1], x.o[2], x.o[3]);
        end
        checks++;
        if (buf_count !== x.cnt || buf_full !== x.full) begin
          fails++;
          $display("FAIL occupancy got count=%0d full=%b want count=%0d full=%b",
                   buf_count, buf_full, x.cnt, x.full);
        end
        checks++;
        if (redirect !== x.red) begin
          fails++;
          $display("FAIL redirect got %b want %b", redirect, x.red);
        end
        checks++;
        if (ovf_err !== x.ovf) begin
          fails++;
          $display("FAIL ovf_err got %b want %b", ovf_err, x.ovf);
        end
      end
    end
  end

  initial begin
    logic r;
    forever begin
      @(negedge clk);
      #2;
      if (rdy_q.size() > 0) begin
        r = rdy_q.pop_front();
        checks++;
        if (inj_ready !== r) begin
          fails++;
          $display("FAIL inj_ready got %b want %b", inj_ready, r);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; ead = '0; wad = '0; nad = '0; sad = '0; sbuff = '0; inj_flit = '0; inj_valid = 1'b0;
    @(negedge clk);
    step(1, rf(50), rf(50), rf(50), rf(50), rf(50), rf(50), 1'b1);
    step(1, '0, '0, '0, '0, '0, '0, 1'b0);
    // Plain pass-through with an empty FIFO.
    step(0, 11'b10000000101, '0, '0, '0, '0, '0, 1'b0);
    // Fill with all slots busy, then overflow, then a full push alongside a pop.
    for (int i = 0; i < 4; i++) step(0, busy(1), busy(1), busy(1), busy(1), busy(0) | 11'h400, '0, 1'b0);
    step(0, busy(1), busy(1), busy(1), busy(1), 11'b10001110001, '0, 1'b0);
    step(0, '0, busy(1), busy(1), busy(1), 11'b10000001111, rf(100), 1'b1);
    // Reinject into slot 0 while the PE is refused.
    step(0, '0, busy(0), busy(1), busy(0), '0, 11'b10011001100, 1'b1);
    for (int i = 0; i < 5; i++) step(0, '0, '0, rf(0), '0, '0, rf(100), 1'b1);
    // Reset in the middle of traffic.
    step(0, busy(0), busy(1), '0, '0, busy(1), rf(100), 1'b1);
    step(1, busy(0), busy(1), rf(50), rf(50), busy(1), rf(100), 1'b1);
    step(1, busy(0), '0, '0, '0, '0, rf(100), 1'b1);
    step(0, '0, '0, '0, '0, 11'b10011001100, '0, 1'b0);
    // Starvation with one non-golden flit in slot 1.
    for (int i = 0; i < 10; i++) step(0, busy(1), busy(0), busy(1), busy(1), '0, '0, 1'b0);
    // All golden: the counter saturates and no redirect happens.
    for (int i = 0; i < 12; i++) step(0, busy(1), busy(1), busy(1), busy(1), '0, '0, 1'b0);
    step(0, busy(1), busy(1), busy(1), busy(1), busy(0), '0, 1'b0);
    step(0, busy(1), busy(1), busy(1), busy(0), '0, '0, 1'b0);
    // Randomized traffic across several load levels.
    for (int ph = 0; ph < 4; ph++) begin
      int pv;
      pv = 40 + ph * 20;
      for (int i = 0; i < 120; i++) begin
        step(($urandom_range(199) == 0), rf(pv), rf(pv), rf(pv), rf(pv), rf(45),
             rf(100), ($urandom_range(1) == 1));
      end
    end
    step(0, '0, '0, '0, '0, '0, '0, 1'b0);
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || rdy_q.size() != 0) begin
      fails++;
      $display("FAIL drain got %0d/%0d pending want 0/0", exp_q.size(), rdy_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
